// File: rtl/divide10_pkg.sv
// divide10_pkg: shared widths and constants for the divide-by-ten unit.
//   VALUE_W      dividend width
//   QUOT_W       quotient width
//   REM_W        remainder width
//   CNT_W        iteration counter width
//   ITERATIONS   quotient bits produced, one per clock
//   DIVISOR_INIT ten aligned under the dividend MSBs (10 << 9)
//   MAX_VALUE    largest dividend whose quotient fits in QUOT_W bits
package divide10_pkg;

    localparam int unsigned VALUE_W    = 14;
    localparam int unsigned QUOT_W     = 10;
    localparam int unsigned REM_W      = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ITERATIONS = 10;

    localparam logic [VALUE_W-1:0] DIVISOR_INIT = 14'd5120;
    localparam logic [VALUE_W-1:0] MAX_VALUE    = 14'd10239;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

endpackage

// File: rtl/divide10_step.sv
// divide10_step: one restoring-division step (compare and conditional subtract).
// Ports:
//   dividend       current partial remainder
//   divisor        current shifted divisor
//   fit            dividend >= divisor, i.e. this quotient bit is 1
//   dividend_next  partial remainder after the step
module divide10_step
    import divide10_pkg::*;
(
    input  logic [VALUE_W-1:0] dividend,
    input  logic [VALUE_W-1:0] divisor,
    output logic               fit,
    output logic [VALUE_W-1:0] dividend_next
);

    always_comb begin
        fit           = (dividend >= divisor);
        dividend_next = fit ? (dividend - divisor) : dividend;
    end

endmodule

// File: rtl/divide_10.sv
// divide_10: sequential restoring divide-by-ten, one quotient bit per clock.
// A start accepted while idle or done launches a 10-cycle division; ready rises
// 10 clocks after the start-sampling edge and holds until the next accepted start.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle request, ignored while a division is running
//   value      unsigned dividend, contract range 0..10239
//   quotient   value / 10 (partial bits visible while running)
//   remainder  value % 10
//   ready      result valid
//   overflow   only with DIVIDE10_OVERFLOW_EN: accepted value exceeded 10239
// Build option: define DIVIDE10_OVERFLOW_EN to add the overflow port and
// force saturated results (1023, 15) for out-of-range dividends.
module divide_10
    import divide10_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic [QUOT_W-1:0]  quotient,
    output logic [REM_W-1:0]   remainder,
`ifdef DIVIDE10_OVERFLOW_EN
    output logic               overflow,
`endif
    output logic               ready
);

    logic [VALUE_W-1:0] dividend;
    logic [VALUE_W-1:0] divisor;
    logic [VALUE_W-1:0] dividend_next;
    logic [CNT_W-1:0]   count;
    logic               run;
    logic               fit;

    divide10_step u_step (
        .dividend      (dividend),
        .divisor       (divisor),
        .fit           (fit),
        .dividend_next (dividend_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend <= '0;
            divisor  <= '0;
            quotient <= '0;
            count    <= '0;
            run      <= 1'b0;
            ready    <= 1'b0;
`ifdef DIVIDE10_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (start && !run) begin
            dividend <= value;
            divisor  <= DIVISOR_INIT;
            quotient <= '0;
            count    <= '0;
            run      <= 1'b1;
            ready    <= 1'b0;
`ifdef DIVIDE10_OVERFLOW_EN
            overflow <= (value > MAX_VALUE);
`endif
        end else if (run) begin
            dividend <= dividend_next;
            divisor  <= divisor >> 1;
            quotient <= {quotient[QUOT_W-2:0], fit};
            count    <= count + CNT_W'(1);
            if (count == LAST_ITER) begin
                run   <= 1'b0;
                ready <= 1'b1;
`ifdef DIVIDE10_OVERFLOW_EN
                // Saturate instead of publishing the wrapped algorithm output.
                if (overflow) begin
                    quotient <= '1;
                end
`endif
            end
        end
    end

`ifdef DIVIDE10_OVERFLOW_EN
    assign remainder = (overflow && ready) ? '1 : dividend[REM_W-1:0];
`else
    assign remainder = dividend[REM_W-1:0];
`endif

endmodule

// File: tb/tb_divide_10.sv
// tb_divide_10: directed self-checking bench for divide_10 with a result scoreboard.
module tb_divide_10;
    import divide10_pkg::*;

    typedef struct {
        int unsigned value;
        int unsigned quot;
        int unsigned rem;
        bit          ovf;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic [VALUE_W-1:0] value;
    logic [QUOT_W-1:0]  quotient;
    logic [REM_W-1:0]   remainder;
    logic               ready;
`ifdef DIVIDE10_OVERFLOW_EN
    logic               overflow;
`endif

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    divide_10 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef DIVIDE10_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns 1 ns after the sampling edge E0.
    task automatic start_div(input int unsigned v);
        exp_t e;
        e.value = v;
        e.quot  = v / 10;
        e.rem   = v % 10;
        e.ovf   = 1'b0;
`ifdef DIVIDE10_OVERFLOW_EN
        if (v > 10239) begin
            e.quot = 1023;
            e.rem  = 15;
            e.ovf  = 1'b1;
        end
`endif
        scoreboard.push_back(e);
        @(negedge clk);
        start = 1'b1;
        value = VALUE_W'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for ready; reports edges waited, 0 on timeout.
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = scoreboard.pop_front();
        check({tag, "_quot"}, 32'(quotient), e.quot);
        check({tag, "_rem"}, 32'(remainder), e.rem);
`ifdef DIVIDE10_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
`endif
    endtask

    task automatic run_one(input string tag, input int unsigned v);
        int edges;
        start_div(v);
        wait_ready(edges);
        check({tag, "_latency"}, 32'(edges), 32'd10);
        compare_result(tag);
    endtask

    initial begin
        int edges;
        bit saw_ready;
        logic [QUOT_W-1:0] held_q;

        rst   = 1'b0;
        start = 1'b0;
        value = '0;
        #12;
        check("reset_quot", 32'(quotient), 32'd0);
        check("reset_rem", 32'(remainder), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_run", 32'(dut.run), 32'd0);
        check("reset_fit", 32'(dut.fit), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // 1024: trace the divisor and check ready stays low until E10.
        start_div(1024);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("trace_divisor_%0d", k), 32'(dut.divisor), 32'd5120 >> k);
            check($sformatf("trace_busy_%0d", k), 32'(ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("v1024_ready", 32'(ready), 32'd1);
        check("v1024_dividend", 32'(dut.dividend), 32'd4);
        compare_result("v1024");

        run_one("v0", 0);
        run_one("v9", 9);
        run_one("v10", 10);
        run_one("v9999", 9999);
        held_q = quotient;
        repeat (5) @(posedge clk);
        #1;
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_quot", 32'(quotient), 32'(held_q));
        run_one("v10239", 10239);

        // Start during iteration 4 must be ignored.
        start_div(1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        value = VALUE_W'(50);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(edges);
        check("ignore_latency", 32'(edges), 32'd6);
        compare_result("v1234");

        // Asynchronous reset mid-division aborts it.
        start_div(5000);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_quot", 32'(quotient), 32'd0);
        check("abort_rem", 32'(remainder), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_run", 32'(dut.run), 32'd0);
        void'(scoreboard.pop_front());
        @(negedge clk);
        rst = 1'b1;
        saw_ready = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) saw_ready = 1'b1;
        end
        check("abort_no_ready", 32'(saw_ready), 32'd0);
        run_one("v77", 77);

`ifdef DIVIDE10_OVERFLOW_EN
        run_one("v12000", 12000);
        run_one("v25", 25);
`endif

        check("sb_drained", 32'(scoreboard.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divide_10.md
# divide_10

Sequential divide-by-ten unit. It converts a 14-bit unsigned binary value into a 10-bit quotient and a 4-bit remainder using restoring shift-subtract division, one quotient bit per clock. It sits in the display path, where it peels decimal digits off binary counts for the seven-segment driver. A start/ready handshake lets a controller chain digit extractions.

## Interface
Parameters: none. Widths are fixed by package constants.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle request; samples `value` and begins a division.
- `value`  in  14  unsigned dividend; valid range 0..10239.
- `quotient`  out  10  `value / 10`; final when `ready`=1.
- `remainder`  out  4  `value % 10`; final when `ready`=1.
- `ready`  out  1  result valid; held high until the next accepted `start` or reset.

## Operation
Internal registers are probed by name from benches and must exist with these names:
- `dividend[13:0]`: running partial remainder.
- `divisor[13:0]`: shifted ten.
- `run`: busy flag.
- 4-bit iteration counter.
- `fit`: combinational flag, `dividend >= divisor`.

States:
- IDLE: `run`=0.
- RUN: `run`=1.
- DONE: `run`=0, `ready`=1.

Transitions:
- Accepted `start` (when `run`=0):
  - `dividend` <= `value`.
  - `divisor` <= 10<<9 (5120).
  - `quotient` <= 0, counter <= 0.
  - `run` <= 1, `ready` <= 0.
- Each RUN cycle:
  - If `fit`, then `dividend` <= `dividend - divisor`.
  - `quotient` <= {`quotient[8:0]`, `fit`}.
  - `divisor` <= `divisor >> 1`.
  - Counter increments.
- On the 10th iteration (counter=9): `run` <= 0 and `ready` <= 1.
- `remainder` = `dividend[3:0]`. After 10 steps `dividend` < 10.
- `start` while `run`=1 is ignored; the division in flight completes undisturbed.
- `start` while `ready`=1 clears `ready` and starts a new division.
- `quotient` shows partial bits while `run`=1. Consumers use it only when `ready`=1.
- `value` > 10239 is out of contract:
  - Timing stays identical.
  - Outputs are whatever the algorithm produces, unless the overflow feature below is enabled.

## Timing
- Reset (`rst`=0, asynchronous) clears everything to 0: `dividend`, `divisor`, `quotient`, counter, `run`, `ready`. Hence `remainder`=0 and `fit`=1, since 0>=0.
- Reset mid-division aborts it. No result and no `ready` follow.
- Edge E0 samples `start`=1. `run` is high after E0.
- Edges E1..E10 perform the 10 iterations. `ready` rises after E10, i.e. latency is 10 clocks from the start-sampling edge.
- Back-to-back: a `start` at E10+1 is accepted. Throughput is 1 division per 11 clocks.

## Configuration
- Macro: `DIVIDE10_OVERFLOW_EN`.
- When defined:
  - Extra output `overflow` (1 bit, reset 0) is added.
  - An accepted `start` with `value` > 10239 latches `overflow`=1.
  - Forced results on `ready`: `quotient`=1023, `remainder`=15.
  - Timing is unchanged.
  - `overflow` clears on the next accepted `start`.
- When undefined: no `overflow` port and no range check.

## Structure
- Package `divide10_pkg` holds:
  - `VALUE_W`=14, `QUOT_W`=10, `REM_W`=4.
  - `ITERATIONS`=10.
  - `DIVISOR_INIT`=14'd5120.
  - `MAX_VALUE`=10239.
- Optional sub-module `divide10_step`: a combinational compare/subtract taking `dividend` and `divisor`, producing `fit` and the next `dividend`.
- The top level holds the registers, counter and handshake.

## Test plan
- Release reset, pulse `start` one cycle with `value`=1024:
  - `quotient`=102, `remainder`=4.
  - `ready` rises 10 clocks after the start edge.
  - `dividend`/`divisor` trace 5120, 2560, ... down to 10.
- Pulse `start` with `value`=0, then `value`=9, then `value`=10:
  - 0 gives (0,0).
  - 9 gives (0,9).
  - 10 gives (1,0).
- Pulse `start` with `value`=9999, then `value`=10239:
  - 9999 gives (999,9).
  - 10239 gives (1023,9).
  - Check `ready` is held until the next start.
- Pulse `start` with `value`=1234, then pulse `start` with `value`=50 at iteration 4: the second start is ignored and the result is (123,4).
- Assert `rst` low at iteration 5:
  - All outputs read 0 immediately (asynchronous).
  - No `ready` appears afterwards.
  - A subsequent `start` with `value`=77 gives (7,7).
- With `DIVIDE10_OVERFLOW_EN`:
  - Pulse `start` with `value`=12000: expect `overflow`=1, (1023,15).
  - Then pulse `start` with `value`=25: expect `overflow`=0, (2,5).
